// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt controller: instruction encodings,
// CSR addresses, trap cause codes and the sequencer state encoding.
package clint_pkg;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

   localparam logic [31:0] CAUSE_ECALL     = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
   localparam logic [31:0] CAUSE_TIMER     = 32'h8000_0007;
   localparam logic [31:0] CAUSE_EXTERNAL  = 32'h8000_000B;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_W_MEPC    = 3'd1,
      S_W_MSTATUS = 3'd2,
      S_W_MCAUSE  = 3'd3,
      S_ASSERT    = 3'd4,
      S_M_MSTATUS = 3'd5,
      S_M_ASSERT  = 3'd6
   } clint_state_e;

   // Trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r    = ms;
      r[7] = ms[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // Trap return: MIE takes the old MPIE, MPIE is set.
   function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r    = ms;
      r[3] = ms[7];
      r[7] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt controller: sequences trap entry (mepc, mstatus, mcause writes
// then redirect to mtvec) and mret (mstatus restore then redirect to mepc).
module clint
   import clint_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  int_flag_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   input  logic [31:0] csr_mtvec,
   input  logic [31:0] csr_mepc,
   input  logic [31:0] csr_mstatus,
   input  logic        global_inter_en_i,
   output logic        hold_flag_o,
   output logic        we_o,
   output logic [31:0] waddr_o,
   output logic [31:0] data_o,
   output logic        int_assert_o,
   output logic [31:0] int_addr_o,
   output logic [2:0]  dbg_state
);

   clint_state_e state;
   logic [31:0]  cause;

   logic        sync_evt;
   logic        async_evt;
   logic        mret_evt;
   logic        event_det;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;

   // Handshake: hold_flag_o is a level request to ctrl; it rises in the same cycle an
   // event is seen in IDLE and stays high until the redirect pulse cycle has passed.
   assign sync_evt  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
   assign async_evt = (int_flag_i != 8'h00) && global_inter_en_i && !hold_flag_i;
   assign mret_evt  = (inst_i == INST_MRET);
   assign event_det = rstn && (state == S_IDLE) && (sync_evt || async_evt || mret_evt);

   assign hold_flag_o = (state != S_IDLE) || event_det;
   assign dbg_state   = state;

   // An async interrupt arriving alongside a taken branch must resume at the branch target.
   assign trap_pc    = sync_evt ? inst_addr_i : (jump_flag_i ? jump_addr_i : inst_addr_i);
   assign trap_cause = sync_evt ? ((inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK)
                                : (int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXTERNAL);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         cause        <= '0;
         we_o         <= 1'b0;
         waddr_o      <= '0;
         data_o       <= '0;
         int_assert_o <= 1'b0;
         int_addr_o   <= '0;
      end else begin
         we_o         <= 1'b0;
         waddr_o      <= '0;
         data_o       <= '0;
         int_assert_o <= 1'b0;
         int_addr_o   <= '0;
         case (state)
            S_IDLE: begin
               if (sync_evt || async_evt) begin
                  state   <= S_W_MEPC;
                  cause   <= trap_cause;
                  we_o    <= 1'b1;
                  waddr_o <= CSR_MEPC;
                  data_o  <= trap_pc;
               end else if (mret_evt) begin
                  state   <= S_M_MSTATUS;
                  we_o    <= 1'b1;
                  waddr_o <= CSR_MSTATUS;
                  data_o  <= mret_mstatus(csr_mstatus);
               end
            end
            S_W_MEPC: begin
               state   <= S_W_MSTATUS;
               we_o    <= 1'b1;
               waddr_o <= CSR_MSTATUS;
               data_o  <= trap_mstatus(csr_mstatus);
            end
            S_W_MSTATUS: begin
               state   <= S_W_MCAUSE;
               we_o    <= 1'b1;
               waddr_o <= CSR_MCAUSE;
               data_o  <= cause;
            end
            S_W_MCAUSE: begin
               state        <= S_ASSERT;
               int_assert_o <= 1'b1;
               int_addr_o   <= csr_mtvec;
            end
            S_M_MSTATUS: begin
               state        <= S_M_ASSERT;
               int_assert_o <= 1'b1;
               int_addr_o   <= csr_mepc;
            end
            S_ASSERT, S_M_ASSERT: state <= S_IDLE;
            default:              state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed scenarios then random traffic, each cycle
// compared against a transaction-level model of the trap/mret output transcript.
module tb_clint;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rstn;
   logic [7:0]  int_flag_i;
   logic [31:0] inst_i;
   logic [31:0] inst_addr_i;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic [31:0] csr_mtvec;
   logic [31:0] csr_mepc;
   logic [31:0] csr_mstatus;
   logic        global_inter_en_i;
   logic        hold_flag_o;
   logic        we_o;
   logic [31:0] waddr_o;
   logic [31:0] data_o;
   logic        int_assert_o;
   logic [31:0] int_addr_o;
   logic [2:0]  dbg_state;

   int errors = 0;
   int checks = 0;

   // Expected per-cycle outputs: {we, waddr, data, int_assert, int_addr}.
   logic [97:0] exp_q[$];

   clint dut (
      .clk(clk), .rstn(rstn), .int_flag_i(int_flag_i), .inst_i(inst_i),
      .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
      .hold_flag_i(hold_flag_i), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .csr_mstatus(csr_mstatus), .global_inter_en_i(global_inter_en_i),
      .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
      .int_assert_o(int_assert_o), .int_addr_o(int_addr_o), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [97:0] wr(input logic [31:0] a, input logic [31:0] d);
      return {1'b1, a, d, 1'b0, 32'h0};
   endfunction

   function automatic logic [97:0] redirect(input logic [31:0] a);
      return {1'b0, 32'h0, 32'h0, 1'b1, a};
   endfunction

   // Reference model: when idle, decide which event the current inputs raise and
   // enqueue its whole output transcript; returns whether the controller is busy.
   function automatic logic model_step(output logic [97:0] cur);
      logic        is_sync, is_async, is_mret;
      logic [31:0] pc, cs, ms;
      cur = '0;
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         return 1'b1;
      end
      is_sync  = (inst_i == ECALL) || (inst_i == EBREAK);
      is_async = (int_flag_i != 0) && global_inter_en_i && !hold_flag_i;
      is_mret  = (inst_i == MRET);
      if (is_sync || is_async) begin
         if (is_sync) begin
            pc = inst_addr_i;
            cs = (inst_i == ECALL) ? 32'd11 : 32'd3;
         end else begin
            pc = jump_flag_i ? jump_addr_i : inst_addr_i;
            cs = int_flag_i[0] ? 32'h8000_0007 : 32'h8000_000B;
         end
         ms = (csr_mstatus & ~32'h88) | (csr_mstatus[3] ? 32'h80 : 32'h0);
         exp_q.push_back(wr(32'h341, pc));
         exp_q.push_back(wr(32'h300, ms));
         exp_q.push_back(wr(32'h342, cs));
         exp_q.push_back(redirect(csr_mtvec));
         return 1'b1;
      end
      if (is_mret) begin
         ms = (csr_mstatus & ~32'h8) | (csr_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
         exp_q.push_back(wr(32'h300, ms));
         exp_q.push_back(redirect(csr_mepc));
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic check_outputs(input string tag, input logic exp_hold, input logic [97:0] e);
      checks++;
      assert (hold_flag_o === exp_hold) else begin
         errors++;
         $error("FAIL %s hold: got %b want %b", tag, hold_flag_o, exp_hold);
      end
      checks++;
      assert ({we_o, waddr_o, data_o} === e[97:33]) else begin
         errors++;
         $error("FAIL %s csr_write: got we=%b a=%h d=%h want we=%b a=%h d=%h", tag,
                we_o, waddr_o, data_o, e[97], e[96:65], e[64:33]);
      end
      checks++;
      assert ({int_assert_o, int_addr_o} === e[32:0]) else begin
         errors++;
         $error("FAIL %s redirect: got %b/%h want %b/%h", tag, int_assert_o, int_addr_o,
                e[32], e[31:0]);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, predict, then compare.
   task automatic tick(input string tag, input logic [31:0] inst, input logic [31:0] ia,
                       input logic [7:0] intf, input logic gie, input logic hin,
                       input logic jf, input logic [31:0] ja, input logic new_csr);
      logic [97:0] cur;
      logic        busy;
      @(negedge clk);
      inst_i = inst; inst_addr_i = ia; int_flag_i = intf; global_inter_en_i = gie;
      hold_flag_i = hin; jump_flag_i = jf; jump_addr_i = ja;
      if (new_csr && exp_q.size() == 0) begin
         csr_mstatus = $urandom();
         csr_mtvec   = $urandom() & 32'hFFFF_FFFC;
         csr_mepc    = $urandom() & 32'hFFFF_FFFC;
      end
      busy = model_step(cur);
      #1;
      check_outputs(tag, busy, cur);
   endtask

   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag, NOP, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      rstn = 1'b0; inst_i = NOP; inst_addr_i = '0; int_flag_i = '0; jump_flag_i = 1'b0;
      jump_addr_i = '0; hold_flag_i = 1'b0; global_inter_en_i = 1'b0;
      csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
      #1;
      check_outputs("reset", 1'b0, '0);
      #6 rstn = 1'b1;

      // ecall trap entry
      csr_mstatus = 32'h8; csr_mtvec = 32'h200; csr_mepc = 32'h0;
      tick("ecall", ECALL, 32'h100, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      quiet("ecall_seq", 6);

      // timer interrupt alongside a taken branch
      tick("timer", NOP, 32'h80, 8'h01, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      quiet("timer_seq", 6);

      // interrupt masked by MIE, then by pipeline hold
      tick("masked_mie", NOP, 32'h90, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick("masked_hold", NOP, 32'h94, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      quiet("masked_after", 1);

      // mret
      csr_mstatus = 32'h80; csr_mepc = 32'h104;
      tick("mret", MRET, 32'h300, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      quiet("mret_seq", 4);

      // ebreak with a concurrent external interrupt held pending; also toggle lines mid-sequence
      csr_mstatus = 32'h88; csr_mtvec = 32'h400;
      tick("ebreak_irq", EBREAK, 32'h180, 8'h02, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick("ebreak_seq", NOP, 32'h184, 8'h01, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++)
         tick("pending_irq", NOP, 32'h184, 8'h02, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      quiet("pending_tail", 5);

      // sync event is taken even while hold_flag_i is high
      tick("ecall_hold", ECALL, 32'h1C0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      quiet("ecall_hold_seq", 5);

      // reset during the mstatus write aborts the sequence
      csr_mstatus = 32'h8;
      tick("rst_ecall", ECALL, 32'h200, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      quiet("rst_seq", 2);
      #2 rstn = 1'b0;
      #1;
      check_outputs("rst_mid", 1'b0, '0);
      checks++;
      assert (dbg_state === 3'd0) else begin
         errors++;
         $error("FAIL rst_state: got %0d want 0", dbg_state);
      end
      exp_q.delete();
      @(posedge clk);
      #2 rstn = 1'b1;
      quiet("rst_after", 4);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] inst;
         logic [7:0]  intf;
         int          r;
         r = $urandom_range(0, 9);
         case (r)
            0:       inst = ECALL;
            1:       inst = EBREAK;
            2:       inst = MRET;
            3:       inst = $urandom();
            default: inst = NOP;
         endcase
         intf = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
         tick("random", inst, $urandom() & 32'hFFFF_FFFC, intf, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom() & 32'hFFFF_FFFC, 1'b1);
      end
      quiet("drain", 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have port clk, input, 1, core clock; all state updates on rising edge.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port int_flag_i, input, 8, external interrupt request lines; bit0 = timer.
REQ-004 SHALL have ports inst_i and inst_addr_i, input, 32 each, instruction in decode/execute and its address.
REQ-005 SHALL have ports jump_flag_i (1) and jump_addr_i (32), input, taken-branch indication and target from execute.
REQ-006 SHALL have port hold_flag_i, input, 1, pipeline-hold from control; blocks async interrupt entry.
REQ-007 SHALL have ports csr_mtvec, csr_mepc and csr_mstatus, input, 32 each, current CSR values from csr_reg.
REQ-008 SHALL have port global_inter_en_i, input, 1, mstatus.MIE from csr_reg.
REQ-009 SHALL have port hold_flag_o, input to ctrl, output, 1, pipeline stall request.
REQ-010 SHALL have ports we_o (1), waddr_o (32) and data_o (32), output, CSR write port into csr_reg clint_we_i, clint_w_addr_i and clint_data_i.
REQ-011 SHALL have ports int_assert_o (1) and int_addr_o (32), output, one-cycle redirect pulse and target to pc_reg.

Function
REQ-012 Events SHALL be sampled only in IDLE.
- ecall = 32'h00000073.
- ebreak = 32'h00100073.
- mret = 32'h30200073.
- async = (int_flag_i != 0) && global_inter_en_i && !hold_flag_i.
REQ-013 Event priority SHALL be: sync (ecall/ebreak) > async > mret; one event is accepted per entry.
REQ-014 States SHALL be IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, M_MSTATUS, M_ASSERT.
REQ-015 hold_flag_o SHALL be combinational: 1 when state != IDLE, or when an event is detected in IDLE.
REQ-016 On a sync or async event in cycle N, the block SHALL latch cause and save_pc, then go to W_MEPC.
- save_pc = inst_addr_i for sync events.
- save_pc = jump_flag_i ? jump_addr_i : inst_addr_i for async events.
REQ-017 Trap sequence, all outputs registered, one state per cycle:
- Cycle N+1: we_o=1, waddr_o=0x341, data_o=save_pc.
- Cycle N+2: we_o=1, waddr_o=0x300, data_o=csr_mstatus with bit7 (MPIE) = old bit3 and bit3 (MIE) = 0.
- Cycle N+3: we_o=1, waddr_o=0x342, data_o=cause.
- Cycle N+4: int_assert_o=1, int_addr_o=csr_mtvec; next state IDLE.
REQ-018 Cause SHALL be:
- ecall 32'd11.
- ebreak 32'd3.
- async with int_flag_i[0] = 32'h80000007.
- any other async = 32'h8000000B.
REQ-019 mret sequence:
- Cycle N+1: we_o=1, waddr_o=0x300, data_o=csr_mstatus with bit3 = old bit7 and bit7 = 1.
- Cycle N+2: int_assert_o=1, int_addr_o=csr_mepc; next state IDLE.
REQ-020 Outside write cycles, we_o, waddr_o and data_o SHALL be 0; outside assert cycles, int_assert_o and int_addr_o SHALL be 0.
REQ-021 int_flag_i changes during a sequence SHALL be ignored.
REQ-022 A request still pending on return to IDLE SHALL be re-evaluated under REQ-012/013.
REQ-023 A sync event in the same cycle as an async request SHALL take the sync path; the async request is re-evaluated after return to IDLE.
REQ-024 In IDLE, hold_flag_i=1 SHALL suppress async entry only; sync events and mret are still taken.

Reset
REQ-025 rstn low SHALL immediately force, regardless of clk:
- state = IDLE;
- we_o, waddr_o, data_o, int_assert_o, int_addr_o, cause, save_pc = 0;
- hold_flag_o = 0, since the state is IDLE and no event is detected during reset.
REQ-026 Reset mid-sequence SHALL abort the sequence with no further CSR writes; any partially written CSRs are left to csr_reg reset.

Structure
REQ-027 CSR addresses, instruction encodings, cause codes and state encodings SHALL live in shared define.v.
REQ-028 The block SHALL be a single module with no sub-modules; it is instantiated in esmilecpu between ctrl, csr_reg and pc_reg.

Verification
REQ-029 ecall at inst_addr_i=0x100, csr_mstatus=0x8, csr_mtvec=0x200 -> the bench SHALL observe:
- writes in order: 0x341 <- 0x100, 0x300 <- 0x80, 0x342 <- 11;
- int_assert_o pulse with int_addr_o=0x200 at N+4;
- hold_flag_o high for N..N+4.
REQ-030 int_flag_i=0x01, global_inter_en_i=1, jump_flag_i=1, jump_addr_i=0x40 -> mepc write SHALL be 0x40 and mcause write 0x80000007.
REQ-031 int_flag_i=0x04 with global_inter_en_i=0, or with hold_flag_i=1 -> no writes, hold_flag_o=0.
REQ-032 mret with csr_mstatus=0x80, csr_mepc=0x104 -> write 0x300 <- 0x88, then int_assert_o with int_addr_o=0x104 at N+2.
REQ-033 ebreak and int_flag_i=0x02 in the same cycle -> the sync path SHALL run first with cause 3; the interrupt is taken after return to IDLE if global_inter_en_i=1.
REQ-034 rstn low during W_MSTATUS -> all outputs 0 immediately; no mcause write follows after release.
